seq_mult: RTL and testbench

SEQ_MULT -- requirements
Module: seq_mult

---
 rtl/seq_mult_pkg.sv | 12 +
 rtl/seq_mult_sign.sv | 12 +
 rtl/seq_mult.sv | 101 ++++++++++
 tb/tb_seq_mult.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package seq_mult_pkg;

    localparam int SEQ_MULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } seq_mult_state_e;

endpackage

// File: rtl/seq_mult_sign.sv
// Two's-complement conditional negate; used for operand magnitude and result sign.
module seq_mult_sign #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/seq_mult.sv
// Radix-2 sequential multiplier, signed/unsigned, valid/ready on both sides.
// Optional accumulate mode (p += product) enabled by defining SEQ_MULT_ACC_EN.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = SEQ_MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               is_signed,
`ifdef SEQ_MULT_ACC_EN
    input  logic               acc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    seq_mult_state_e state;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    part;
    logic [CW-1:0]    cnt;
    logic             neg;
`ifdef SEQ_MULT_ACC_EN
    logic             acc_q;
`endif

    logic [WIDTH-1:0] xmag, ymag;
    logic [PW-1:0]    sum, res, nxt_p;
    logic             last;

    // Magnitudes of the most-negative value still fit in WIDTH unsigned bits.
    seq_mult_sign #(.W(WIDTH)) u_xabs (.a(x), .neg(is_signed & x[WIDTH-1]), .y(xmag));
    seq_mult_sign #(.W(WIDTH)) u_yabs (.a(y), .neg(is_signed & y[WIDTH-1]), .y(ymag));
    seq_mult_sign #(.W(PW))    u_res  (.a(sum), .neg(neg), .y(res));

    assign sum  = part + (mplier[0] ? mcand : '0);
    assign last = (cnt == CW'(WIDTH - 1));
`ifdef SEQ_MULT_ACC_EN
    assign nxt_p = acc_q ? (p + res) : res;
`else
    assign nxt_p = res;
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mcand  <= '0;
            mplier <= '0;
            part   <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            p      <= '0;
`ifdef SEQ_MULT_ACC_EN
            acc_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, xmag};
                        mplier <= ymag;
                        part   <= '0;
                        cnt    <= '0;
                        neg    <= is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
`ifdef SEQ_MULT_ACC_EN
                        acc_q  <= acc;
`endif
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    part   <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        p     <= nxt_p;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Randomized self-checking bench for seq_mult against an arithmetic reference model.
module tb_seq_mult;

`ifdef SEQ_MULT_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, is_signed = 1'b0, out_valid, out_ready = 1'b0;
    logic [7:0]  x = '0, y = '0;
    logic [15:0] p;
`ifdef SEQ_MULT_ACC_EN
    logic        acc = 1'b0;
`endif

    logic        in_valid16 = 1'b0, in_ready16, is_signed16 = 1'b0, out_valid16, out_ready16 = 1'b0;
    logic [15:0] x16 = '0, y16 = '0;
    logic [31:0] p16;

    int nvec = 0;
    int nerr = 0;
    logic [15:0] pexp = '0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .is_signed(is_signed),
`ifdef SEQ_MULT_ACC_EN
        .acc(acc),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    seq_mult #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .x(x16), .y(y16), .is_signed(is_signed16),
`ifdef SEQ_MULT_ACC_EN
        .acc(1'b0),
`endif
        .out_valid(out_valid16), .out_ready(out_ready16), .p(p16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product, optionally added to the previous result.
    function automatic logic [15:0] mdl8(input logic [7:0] a, input logic [7:0] b,
                                         input bit s, input bit ac);
        longint pa, pb, r;
        logic [63:0] rv;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        r  = pa * pb;
        if (ACC && ac) r = r + longint'(pexp);
        rv = 64'(r);
        return rv[15:0];
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s,
                       input bit ac, input int hold);
        int n;
        logic [15:0] e;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("in_ready_before_op", 64'(in_ready), 64'd1);
        x = a; y = b; is_signed = s; in_valid = 1'b1;
`ifdef SEQ_MULT_ACC_EN
        acc = ac;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 8'($urandom); y = 8'($urandom); is_signed = 1'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency", 64'(n), 64'd8);
        e = mdl8(a, b, s, ac);
        chk("product", 64'(p), 64'(e));
        pexp = e;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_p", 64'(p), 64'(e));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_after_accept", 64'(in_ready), 64'd1);
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("p_retained", 64'(p), 64'(e));
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit s,
                        input logic [31:0] e);
        int n;
        x16 = a; y16 = b; is_signed16 = s; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        n = 0;
        while (!out_valid16 && n < 60) begin @(posedge clk); #1; n++; end
        chk("w16_latency", 64'(n), 64'd16);
        chk("w16_product", 64'(p16), 64'(e));
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        chk("w16_idle", 64'(in_ready16), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_p", 64'(p), 64'd0);
        chk("rst_p16", 64'(p16), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        op8(8'd255, 8'd255, 1'b0, 1'b0, 0);
        chk("unsigned_ff", 64'(p), 64'h0000_0000_0000_FE01);
        op8(8'h80, 8'h80, 1'b1, 1'b0, 0);
        chk("s_min_min", 64'(p), 64'h4000);
        op8(8'hFD, 8'h07, 1'b1, 1'b0, 0);
        chk("s_m3_7", 64'(p), 64'hFFEB);
        op8(8'h80, 8'h7F, 1'b1, 1'b0, 5);
        chk("s_min_max", 64'(p), 64'hC080);

        // Abort mid-operation with an asynchronous reset.
        x = 8'd9; y = 8'd9; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_p", 64'(p), 64'd0);
        #3 rst_n = 1'b1;
        pexp = '0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        op8(8'd6, 8'd7, 1'b0, 1'b0, 0);
        chk("after_abort", 64'(p), 64'd42);

`ifdef SEQ_MULT_ACC_EN
        op8(8'd3, 8'd4, 1'b0, 1'b0, 0);
        chk("acc_first", 64'(p), 64'd12);
        op8(8'd5, 8'd6, 1'b0, 1'b1, 0);
        chk("acc_second", 64'(p), 64'd42);
`endif

        for (int i = 0; i < 40; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)));

        op16(16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE);
        op16(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE);
        op16(16'h8000, 16'h8000, 1'b1, 32'h40000000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
